// File: rtl/fnd_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with a sequential double-dabble BCD converter.
// Optional leading-zero blanking above DP_DIGIT when FND_LEADING_ZERO_BLANK_EN is defined.
module fnd_scan_driver #(
  parameter int SCAN_DIV = 100_000,
  parameter int DP_DIGIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] seg_data,
  input  logic        dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        seg_dp,
  output logic        conv_busy
);

  localparam int          CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [1:0]  DP_IDX = DP_DIGIT[1:0];
  localparam logic [13:0] MAX_VAL = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  // One double-dabble step: add-3 on nibbles >= 5, then shift in the next binary bit.
  function automatic logic [15:0] bcd_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] adj;
    for (int k = 0; k < 4; k++) begin
      if (b[4*k +: 4] >= 4'd5) adj[4*k +: 4] = b[4*k +: 4] + 4'd3;
      else                     adj[4*k +: 4] = b[4*k +: 4];
    end
    return {adj[14:0], in_bit};
  endfunction

  state_t      state_r, state_s;
  logic        busy_r;
  logic [13:0] bin_r;
  logic [15:0] bcd_r;
  logic [3:0]  shcnt_r;
  logic        dp_cap_r;
  logic [15:0] disp_r;
  logic        disp_dp_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]  idx_r;
  logic [3:0]  an_r;
  logic [6:0]  seg_r;
  logic        seg_dp_r;
  logic [3:0]  digit_s;
  logic        blank_s;

  // Converter next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  state_s = ST_SHIFT;
      ST_SHIFT: begin
        if (shcnt_r == 4'd13) state_s = ST_LOAD;
        else                  state_s = ST_SHIFT;
      end
      ST_LOAD:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Converter state register and registered busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  // Converter datapath; display registers only change in LOAD so digits never tear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_r     <= 14'd0;
      bcd_r     <= 16'd0;
      shcnt_r   <= 4'd0;
      dp_cap_r  <= 1'b0;
      disp_r    <= 16'd0;
      disp_dp_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bin_r    <= (seg_data > MAX_VAL) ? MAX_VAL : seg_data;
          dp_cap_r <= dp;
          bcd_r    <= 16'd0;
          shcnt_r  <= 4'd0;
        end
        ST_SHIFT: begin
          bcd_r   <= bcd_step(bcd_r, bin_r[13]);
          bin_r   <= {bin_r[12:0], 1'b0};
          shcnt_r <= shcnt_r + 4'd1;
        end
        ST_LOAD: begin
          disp_r    <= bcd_r;
          disp_dp_r <= dp_cap_r;
        end
        default: begin
          bcd_r <= 16'd0;
        end
      endcase
    end
  end

  // Digit select and optional leading-zero blanking for the current scan index.
  always_comb begin
    digit_s = disp_r[{idx_r, 2'b00} +: 4];
    blank_s = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (idx_r > DP_IDX) begin
      blank_s = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if ((2'(j) >= idx_r) && (disp_r[4*j +: 4] != 4'd0)) blank_s = 1'b0;
        else                                                  blank_s = blank_s;
      end
    end else begin
      blank_s = 1'b0;
    end
`endif
  end

  // Scan counter, digit index and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= '0;
      idx_r    <= 2'd0;
      an_r     <= 4'b1111;
      seg_r    <= 7'h7F;
      seg_dp_r <= 1'b1;
    end else begin
      if (cnt_r == CNT_W'(SCAN_DIV - 1)) begin
        cnt_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      an_r     <= ~(4'b0001 << idx_r);
      seg_r    <= blank_s ? 7'h7F : seg_decode(digit_s);
      seg_dp_r <= ~((idx_r == DP_IDX) && disp_dp_r);
    end
  end

  assign an        = an_r;
  assign seg       = seg_r;
  assign seg_dp    = seg_dp_r;
  assign conv_busy = busy_r;

endmodule
